serial_mem_loader: RTL

//  Parametrised serial programming slave that loads and reads back the on-chip memories (icache, dcache, ...).

---
 rtl/serial_mem_loader_pkg.sv | 18 +
 rtl/serial_mem_loader_if.sv | 26 ++
 rtl/serial_shifter.sv | 24 ++
 rtl/serial_mem_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_mem_loader_pkg.sv
`default_nettype none
// ==== serial_mem_loader_pkg : shared FSM encoding, command values, clog2 helper (rev 1.0) ====
`ifndef SML_CLOG2
`define SML_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package serial_mem_loader_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_WDATA    = 3'd2;
  localparam logic [2:0] ST_RLOAD    = 3'd3;
  localparam logic [2:0] ST_RDATA    = 3'd4;
  localparam logic [2:0] ST_WAIT_REL = 3'd5;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;
endpackage
`default_nettype wire

// File: rtl/serial_mem_loader_if.sv
`default_nettype none
// ==== serial_mem_loader_if : serial pins plus target memory write/read port bundle (rev 1.0) ====
interface serial_mem_loader_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NUM_TGT = 2
);
  logic [NUM_TGT-1:0]        cs_n_in;
  logic                      sdata_in;
  logic                      sdata_out;
  logic [NUM_TGT-1:0]        mem_wen_out;
  logic [ADDR_W-1:0]         mem_addr_out;
  logic [DATA_W-1:0]         mem_data_out;
  logic [NUM_TGT*DATA_W-1:0] mem_rdata_in;

  modport master (
    output cs_n_in, sdata_in, mem_rdata_in,
    input  sdata_out, mem_wen_out, mem_addr_out, mem_data_out
  );

  modport slave (
    input  cs_n_in, sdata_in, mem_rdata_in,
    output sdata_out, mem_wen_out, mem_addr_out, mem_data_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_shifter.sv
`default_nettype none
// ==== serial_shifter : MSB-first shift register with parallel load, shift enable, async clear (rev 1.0) ====
module serial_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] pdata,
  input  logic         sin,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end
endmodule
`default_nettype wire

// File: rtl/serial_mem_loader.sv
`default_nettype none
// ==== serial_mem_loader : serial slave that burst-writes and reads back N target memories (rev 1.0) ====
module serial_mem_loader
  import serial_mem_loader_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NUM_TGT = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_mem_loader_if.slave bus,
  output logic               busy_out,
  output logic               err_out,
  output logic [CNT_W-1:0]   wr_cnt_out
);
  localparam int RX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BC_W  = `SML_CLOG2(RX_W + 1);
  localparam int TGT_W = `SML_CLOG2(NUM_TGT);
  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

  logic [2:0]         state;
  logic [2:0]         abort_state;
  logic [BC_W-1:0]    bit_cnt;
  logic [TGT_W-1:0]   tgt;
  logic [TGT_W-1:0]   sel_idx;
  logic               cmd;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  maddr;
  logic [DATA_W-1:0]  wdata;
  logic [NUM_TGT-1:0] wen;
  logic [NUM_TGT-1:0] sel_vec;
  logic               sel_none;
  logic               sel_one;
  logic               sel_ok;
  logic [CNT_W-1:0]   wr_cnt;
  logic [RX_W-1:0]    rx_q;
  logic [RX_W-1:0]    rx_next;
  logic [DATA_W-1:0]  tx_q;
  logic [DATA_W-1:0]  rd_word;
  logic               rx_shift;
  logic               tx_load;
  logic               tx_shift;
  logic               unused_shift_bits;

  assign sel_vec     = ~bus.cs_n_in;
  assign sel_none    = (sel_vec == '0);
  assign sel_one     = !sel_none && ((sel_vec & (sel_vec - NUM_TGT'(1))) == '0);
  assign sel_ok      = (sel_vec == (NUM_TGT'(1) << tgt));
  assign abort_state = sel_none ? ST_IDLE : ST_WAIT_REL;
  assign rx_next     = {rx_q[RX_W-2:0], bus.sdata_in};

  always_comb begin
    sel_idx = '0;
    rd_word = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (sel_vec[k]) sel_idx = TGT_W'(k);
      if (tgt == TGT_W'(k)) rd_word = bus.mem_rdata_in[k*DATA_W +: DATA_W];
    end
  end

  assign rx_shift = ((state == ST_HDR) || (state == ST_WDATA)) && sel_ok;
  assign tx_load  = (state == ST_RLOAD) && sel_ok;
  assign tx_shift = (state == ST_RDATA) && sel_ok;

  serial_shifter #(.W(RX_W)) u_rx (
    .clk(clk), .rst(rst), .load(1'b0), .shift_en(rx_shift),
    .pdata('0), .sin(bus.sdata_in), .q(rx_q)
  );

  serial_shifter #(.W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .load(tx_load), .shift_en(tx_shift),
    .pdata(rd_word), .sin(1'b0), .q(tx_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tgt     <= '0;
      cmd     <= CMD_RD;
      addr    <= '0;
      maddr   <= '0;
      wdata   <= '0;
      wen     <= '0;
      err_out <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      wen     <= '0;
      err_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_one) begin
            tgt     <= sel_idx;
            cmd     <= bus.sdata_in;
            bit_cnt <= '0;
            state   <= ST_HDR;
          end else if (!sel_none) begin
            err_out <= 1'b1;
            state   <= ST_WAIT_REL;
          end
        end
        ST_HDR: begin
          if (!sel_ok) begin
            err_out <= 1'b1;
            state   <= abort_state;
          end else if (bit_cnt == ADDR_LAST) begin
            addr    <= rx_next[ADDR_W-1:0];
            bit_cnt <= '0;
            if (cmd == CMD_WR) begin
              state <= ST_WDATA;
            end else begin
              maddr <= rx_next[ADDR_W-1:0];
              state <= ST_RLOAD;
            end
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        ST_WDATA: begin
          // Release exactly between words ends a burst cleanly.
          if (!sel_ok) begin
            if ((bit_cnt == '0) && sel_none) begin
              state <= ST_IDLE;
            end else begin
              err_out <= 1'b1;
              state   <= abort_state;
            end
          end else if (bit_cnt == DATA_LAST) begin
            wen     <= NUM_TGT'(1) << tgt;
            maddr   <= addr;
            wdata   <= rx_next[DATA_W-1:0];
            addr    <= addr + ADDR_W'(1);
            bit_cnt <= '0;
            if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        ST_RLOAD: begin
          if (!sel_ok) begin
            err_out <= 1'b1;
            state   <= abort_state;
          end else begin
            bit_cnt <= '0;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (!sel_ok) begin
            err_out <= 1'b1;
            state   <= abort_state;
          end else if (bit_cnt == DATA_LAST) begin
            state <= ST_WAIT_REL;
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        ST_WAIT_REL: begin
          if (sel_none) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_wen_out  = wen;
  assign bus.mem_addr_out = maddr;
  assign bus.mem_data_out = wdata;
  assign bus.sdata_out    = (state == ST_RDATA) && tx_q[DATA_W-1];
  assign busy_out         = (state != ST_IDLE);
  assign wr_cnt_out       = wr_cnt;

  assign unused_shift_bits = ^{rx_q[RX_W-1], tx_q[DATA_W-2:0]};
endmodule
`default_nettype wire
